// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled binary / Gray / scanner / hold patterns.
// Optional LED_PWM_EN adds a 4-bit brightness input and PWM gating of led.
module led_pattern_gen #(
  parameter int WIDTH         = 8,
  parameter int PRESCALE_BITS = 21,
  parameter int INVERT_OUT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef LED_PWM_EN
  input  logic [3:0]       bright,
`endif
  output logic             tick,
  output logic [WIDTH-1:0] led
);

  localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] OFF = (INVERT_OUT != 0) ? '1 : '0;

  localparam logic [0:0] SCAN_UP   = 1'b0;
  localparam logic [0:0] SCAN_DOWN = 1'b1;

  logic [PRESCALE_BITS-1:0] prescaler;
  logic [WIDTH-1:0]         cnt;
  logic [PW-1:0]            pos;
  logic [0:0]               state;
  logic [WIDTH-1:0]         pat_q;
  logic [WIDTH-1:0]         next_pat;
  logic [WIDTH-1:0]         led_next;
  logic                     step;

  logic is_bin, is_gray, is_scan, is_hold;
  assign is_bin  = (mode == 2'b00);
  assign is_gray = (mode == 2'b01);
  assign is_scan = (mode == 2'b10);
  assign is_hold = (mode == 2'b11);

  assign step = en && (&prescaler);

  // Hold replays the last pattern so led stays frozen.
  always_comb begin
    next_pat = pat_q;
    unique case (1'b1)
      is_bin:  next_pat = cnt;
      is_gray: next_pat = cnt ^ (cnt >> 1);
      is_scan: next_pat = WIDTH'(1) << pos;
      is_hold: next_pat = pat_q;
      default: next_pat = pat_q;
    endcase
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rst) pwm_cnt <= '0;
    else      pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign led_next = (pwm_cnt >= bright) ? OFF : (next_pat ^ OFF);
`else
  assign led_next = next_pat ^ OFF;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler <= '0;
      cnt       <= '0;
      pos       <= '0;
      state     <= SCAN_UP;
      tick      <= 1'b0;
      pat_q     <= '0;
      led       <= OFF;
    end else begin
      pat_q <= next_pat;
      led   <= led_next;
      if (load) begin
        cnt       <= load_val;
        prescaler <= '0;
        pos       <= '0;
        state     <= SCAN_UP;
        tick      <= 1'b0;
      end else if (step) begin
        prescaler <= '0;
        tick      <= 1'b1;
        unique case (1'b1)
          is_bin, is_gray: begin
            if (dir) cnt <= cnt + 1'b1;
            else     cnt <= cnt - 1'b1;
          end
          is_scan: begin
            if (state == SCAN_UP) begin
              if (pos == POS_MAX) begin
                pos   <= POS_MAX - 1'b1;
                state <= SCAN_DOWN;
              end else begin
                pos <= pos + 1'b1;
              end
            end else begin
              if (pos == '0) begin
                pos   <= PW'(1);
                state <= SCAN_UP;
              end else begin
                pos <= pos - 1'b1;
              end
            end
          end
          is_hold: ;
          default: ;
        endcase
      end else begin
        if (en) prescaler <= prescaler + 1'b1;
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized self-checking bench for led_pattern_gen (W=8, P=2, active-low).
// Reference model tracks the scanner as an index into a bouncing cycle.
module tb_led_pattern_gen;

  localparam int W  = 8;
  localparam int PB = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         dir = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         tick;
  logic [W-1:0] led;

  led_pattern_gen #(
    .WIDTH(W), .PRESCALE_BITS(PB), .INVERT_OUT(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .tick(tick), .led(led)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int m_presc, m_cnt, m_idx, m_pat, m_led;
  bit m_tick;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int scan_pos(input int idx);
    return (idx < W) ? idx : (2 * W - 2 - idx);
  endfunction

  function automatic int cur_pat();
    case (mode)
      2'b00:   return m_cnt;
      2'b01:   return m_cnt ^ (m_cnt >> 1);
      2'b10:   return 1 << scan_pos(m_idx);
      default: return m_pat;
    endcase
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_presc = 0; m_cnt = 0; m_idx = 0; m_tick = 0;
      m_pat = 0; m_led = 'hFF;
    end else begin
      m_pat = cur_pat();
      m_led = m_pat ^ 'hFF;
      if (load) begin
        m_cnt = int'(load_val); m_presc = 0; m_idx = 0; m_tick = 0;
      end else if (en && m_presc == (1 << PB) - 1) begin
        m_presc = 0;
        m_tick  = 1;
        if (mode == 2'b00 || mode == 2'b01)
          m_cnt = (m_cnt + (dir ? 1 : 255)) % 256;
        else if (mode == 2'b10)
          m_idx = (m_idx + 1) % (2 * W - 2);
      end else begin
        if (en) m_presc++;
        m_tick = 0;
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check({tag, "_tick"}, 32'(tick), 32'(m_tick));
    check({tag, "_led"}, 32'(led), 32'(m_led[W-1:0]));
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    cycles(3, "rst");
    check("rst_led_const", 32'(led), 32'hFF);

    rst = 1'b1; en = 1'b1; mode = 2'b00; dir = 1'b1;
    cycles(3, "t1");
    cycle("t1_edge4");
    check("t1_tick4", 32'(tick), 32'd1);
    cycle("t1_edge5");
    check("t1_led_fe", 32'(led), 32'hFE);
    cycles(10, "t1_period");

    rst = 1'b0; cycle("t2_rst");
    rst = 1'b1; dir = 1'b0;
    cycles(5, "t2");
    check("t2_wrap", 32'(led), 32'h00);

    en = 1'b0; mode = 2'b01; load = 1'b1; load_val = 8'h03;
    cycle("t3_ld");
    load = 1'b0;
    cycle("t3_hold");
    check("t3_fd", 32'(led), 32'hFD);
    en = 1'b1; dir = 1'b1;
    cycles(5, "t3_step");
    check("t3_f9", 32'(led), 32'hF9);

    rst = 1'b0; cycle("t4_rst");
    rst = 1'b1; mode = 2'b10;
    for (int i = 0; i < 64; i++) begin
      dir = ~dir;
      cycle("t4_scan");
    end

    mode = 2'b00;
    cycles(3, "t5_pre");
    load = 1'b1; load_val = 8'hA5;
    cycle("t5_ld");
    check("t5_tick0", 32'(tick), 32'd0);
    load = 1'b0;
    cycles(6, "t5_run");
    rst = 1'b0; cycle("t5_rst");
    rst = 1'b1; cycle("t5_after");
    check("t5_ff", 32'(led), 32'hFF);

    mode = 2'b11;
    cycles(12, "t6_hold");
    cycles(2, "t6_part");
    en = 1'b0;
    cycles(10, "t6_en0");
    en = 1'b1;
    cycles(8, "t6_resume");

    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      load = ($urandom_range(0, 24) == 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 7) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
